// File: rtl/aes_pkg.sv
// Shared AES definitions for the byte-substitution scheduler: FSM states,
// beat counts per request type and the legal lane-count check.
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN_ST,
        RUN_KW,
        DONE_ST,
        DONE_KW
    } state_t;

    localparam int ST_BYTES = 16;
    localparam int KW_BYTES = 4;

    function automatic bit lanes_legal(input int lanes);
        return (lanes == 1) || (lanes == 2) || (lanes == 4);
    endfunction

    function automatic int st_beats(input int lanes);
        return ST_BYTES / lanes;
    endfunction

    function automatic int kw_beats(input int lanes);
        return KW_BYTES / lanes;
    endfunction

endpackage

// File: rtl/sbox.sv
// AES forward S-box, purely combinational table lookup.
module sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    // Row r holds the substitutions for inputs r0..rf, first entry in the top byte.
    localparam logic [2047:0] TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign dout = TBL[11'd2047 - {din, 3'b000} -: 8];

endmodule

// File: rtl/sbox_sched.sv
// Time-shares LANES S-box instances between 128-bit state SubBytes requests
// and 32-bit key-schedule SubWord requests, with round-robin arbitration.
module sbox_sched
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st_req_valid,
    output logic         st_req_ready,
    input  logic [127:0] st_in,
    output logic         st_out_valid,
    input  logic         st_out_ready,
    output logic [127:0] st_out,
    input  logic         kw_req_valid,
    output logic         kw_req_ready,
    input  logic [31:0]  kw_in,
    output logic         kw_out_valid,
    input  logic         kw_out_ready,
    output logic [31:0]  kw_out,
    output logic         busy
);

    localparam logic [3:0] ST_LAST = 4'(st_beats(LANES) - 1);
    localparam logic [3:0] KW_LAST = 4'(kw_beats(LANES) - 1);

    if (!lanes_legal(LANES)) begin : g_bad_lanes
        $error("sbox_sched: LANES must be 1, 2 or 4");
    end

    state_t       state, nxt;
    logic [3:0]   cnt;
    logic [127:0] work, work_nxt;
    logic         last_kw;
    logic         armed;
    logic         grant_st, grant_kw;
    logic         last_beat;
    logic [3:0]   bidx   [LANES];
    logic [7:0]   sb_in  [LANES];
    logic [7:0]   sb_out [LANES];

    // Round-robin: on contention, the side not granted last time wins.
    assign grant_st = st_req_valid && (!kw_req_valid || last_kw);
    assign grant_kw = kw_req_valid && (!st_req_valid || !last_kw);
    assign busy     = (state != IDLE);

    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            bidx[j]  = 4'(int'(cnt) * LANES + j);
            sb_in[j] = work[8 * (15 - int'(bidx[j])) +: 8];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sbox u_sbox (
            .din  (sb_in[g]),
            .dout (sb_out[g])
        );
    end

    always_comb begin
        work_nxt = work;
        for (int j = 0; j < LANES; j++) begin
            work_nxt[8 * (15 - int'(bidx[j])) +: 8] = sb_out[j];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt          = state;
        st_req_ready = 1'b0;
        kw_req_ready = 1'b0;
        st_out_valid = 1'b0;
        kw_out_valid = 1'b0;
        last_beat    = 1'b0;
        unique case (state)
            IDLE: begin
                st_req_ready = armed && grant_st;
                kw_req_ready = armed && grant_kw;
                if (st_req_ready) begin
                    nxt = RUN_ST;
                end else if (kw_req_ready) begin
                    nxt = RUN_KW;
                end
            end
            RUN_ST: begin
                last_beat = (cnt == ST_LAST);
                if (last_beat) nxt = DONE_ST;
            end
            RUN_KW: begin
                last_beat = (cnt == KW_LAST);
                if (last_beat) nxt = DONE_KW;
            end
            DONE_ST: begin
                st_out_valid = 1'b1;
                if (st_out_ready) nxt = IDLE;
            end
            DONE_KW: begin
                kw_out_valid = 1'b1;
                if (kw_out_ready) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // armed keeps both readies low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed   <= 1'b0;
            last_kw <= 1'b0;
            cnt     <= '0;
            work    <= '0;
            st_out  <= '0;
            kw_out  <= '0;
        end else begin
            armed <= 1'b1;
            if (st_req_ready) begin
                work    <= st_in;
                cnt     <= '0;
                last_kw <= 1'b0;
            end else if (kw_req_ready) begin
                work    <= {kw_in, work[95:0]};
                cnt     <= '0;
                last_kw <= 1'b1;
            end else if (state == RUN_ST || state == RUN_KW) begin
                work <= work_nxt;
                cnt  <= last_beat ? 4'd0 : cnt + 4'd1;
                if (last_beat && state == RUN_ST) st_out <= work_nxt;
                if (last_beat && state == RUN_KW) kw_out <= work_nxt[127:96];
            end
        end
    end

endmodule

// File: tb/tb_sbox_sched.sv
// Directed bench for sbox_sched: one LANES=4 instance and one LANES=1 instance.
module tb_sbox_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    logic         sv_a = 0, sr_a, sov_a, sor_a = 0, kv_a = 0, kr_a, kov_a, kor_a = 0, busy_a;
    logic [127:0] si_a = '0, so_a;
    logic [31:0]  ki_a = '0, ko_a;
    logic         sv_b = 0, sr_b, sov_b, sor_b = 0, kv_b = 0, kr_b, kov_b, kor_b = 0, busy_b;
    logic [127:0] si_b = '0, so_b;
    logic [31:0]  ki_b = '0, ko_b;

    int n_cmp = 0;
    int n_err = 0;

    sbox_sched #(.LANES(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .st_req_valid(sv_a), .st_req_ready(sr_a), .st_in(si_a),
        .st_out_valid(sov_a), .st_out_ready(sor_a), .st_out(so_a),
        .kw_req_valid(kv_a), .kw_req_ready(kr_a), .kw_in(ki_a),
        .kw_out_valid(kov_a), .kw_out_ready(kor_a), .kw_out(ko_a),
        .busy(busy_a)
    );

    sbox_sched #(.LANES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .st_req_valid(sv_b), .st_req_ready(sr_b), .st_in(si_b),
        .st_out_valid(sov_b), .st_out_ready(sor_b), .st_out(so_b),
        .kw_req_valid(kv_b), .kw_req_ready(kr_b), .kw_in(ki_b),
        .kw_out_valid(kov_b), .kw_out_ready(kor_b), .kw_out(ko_b),
        .busy(busy_b)
    );

    // Reference S-box built from GF(2^8) inversion plus the AES affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] v);
        logic [7:0] inv = 8'h00;
        for (int c = 1; c < 256; c++) begin
            if (gmul(v, 8'(c)) == 8'h01) inv = 8'(c);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_ref(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox_ref(s[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [31:0] kw_ref(input logic [31:0] s);
        logic [31:0] o;
        for (int i = 0; i < 4; i++) o[8*i +: 8] = sbox_ref(s[8*i +: 8]);
        return o;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic st_accept(input bit b, input logic [127:0] d);
        int w = 0;
        if (b) begin si_b = d; sv_b = 1'b1; end
        else   begin si_a = d; sv_a = 1'b1; end
        #1;
        while (!(b ? sr_b : sr_a) && w < 40) begin
            tick();
            w++;
        end
        chk1("st_req_ready", b ? sr_b : sr_a, 1'b1);
        tick();
        if (b) sv_b = 1'b0; else sv_a = 1'b0;
    endtask

    task automatic kw_accept(input bit b, input logic [31:0] d);
        int w = 0;
        if (b) begin ki_b = d; kv_b = 1'b1; end
        else   begin ki_a = d; kv_a = 1'b1; end
        #1;
        while (!(b ? kr_b : kr_a) && w < 40) begin
            tick();
            w++;
        end
        chk1("kw_req_ready", b ? kr_b : kr_a, 1'b1);
        tick();
        if (b) kv_b = 1'b0; else kv_a = 1'b0;
    endtask

    task automatic st_wait(input bit b, input int lat);
        for (int i = 1; i <= lat; i++) begin
            tick();
            chk1("st_out_valid_latency", b ? sov_b : sov_a, i == lat);
        end
    endtask

    task automatic kw_wait(input bit b, input int lat);
        for (int i = 1; i <= lat; i++) begin
            tick();
            chk1("kw_out_valid_latency", b ? kov_b : kov_a, i == lat);
        end
    endtask

    task automatic st_take(input bit b, input logic [127:0] exp);
        chk("st_out", b ? so_b : so_a, exp);
        if (b) sor_b = 1'b1; else sor_a = 1'b1;
        tick();
        if (b) sor_b = 1'b0; else sor_a = 1'b0;
        chk1("st_out_valid_clear", b ? sov_b : sov_a, 1'b0);
        chk("st_out_hold", b ? so_b : so_a, exp);
    endtask

    task automatic kw_take(input bit b, input logic [31:0] exp);
        chk("kw_out", {96'd0, b ? ko_b : ko_a}, {96'd0, exp});
        if (b) kor_b = 1'b1; else kor_a = 1'b1;
        tick();
        if (b) kor_b = 1'b0; else kor_a = 1'b0;
        chk1("kw_out_valid_clear", b ? kov_b : kov_a, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    localparam logic [127:0] FIPS_IN  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;
    localparam logic [127:0] D2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] D3 = 128'hdeadbeef0123456789abcdeffedcba98;

    initial begin
        logic [127:0] d;

        // Reset state, with requests pending while reset is held.
        sv_a = 1'b1; kv_a = 1'b1; sv_b = 1'b1; kv_b = 1'b1;
        tick();
        chk1("rst_st_ready", sr_a, 1'b0);
        chk1("rst_kw_ready", kr_a, 1'b0);
        chk1("rst_busy", busy_a, 1'b0);
        chk1("rst_st_valid", sov_a, 1'b0);
        chk1("rst_kw_valid", kov_a, 1'b0);
        chk("rst_st_out", so_a, 128'd0);
        chk("rst_kw_out", {96'd0, ko_a}, 128'd0);
        chk1("rst_b_st_ready", sr_b, 1'b0);
        chk1("rst_b_busy", busy_b, 1'b0);
        sv_a = 1'b0; kv_a = 1'b0; sv_b = 1'b0; kv_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ST alone and KW alone, LANES=4.
        st_accept(0, FIPS_IN);
        chk1("st_busy_run", busy_a, 1'b1);
        st_wait(0, 4);
        st_take(0, FIPS_OUT);
        chk1("st_busy_idle", busy_a, 1'b0);
        kw_accept(0, 32'h09cf4f3c);
        kw_wait(0, 1);
        kw_take(0, 32'h018a84eb);

        // LANES=1 instance.
        kw_accept(1, 32'h09cf4f3c);
        kw_wait(1, 4);
        kw_take(1, 32'h018a84eb);
        st_accept(1, FIPS_IN);
        st_wait(1, 16);
        st_take(1, FIPS_OUT);

        // Backpressure with a KW request waiting behind it.
        st_accept(0, D2);
        st_wait(0, 4);
        ki_a = 32'h2b7e1516; kv_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk1("bp_st_valid", sov_a, 1'b1);
            chk("bp_st_out", so_a, sub_ref(D2));
            chk1("bp_busy", busy_a, 1'b1);
            chk1("bp_kw_ready", kr_a, 1'b0);
            tick();
        end
        st_take(0, sub_ref(D2));
        chk1("bp_kw_ready_after", kr_a, 1'b1);
        kw_accept(0, 32'h2b7e1516);
        kw_wait(0, 1);
        kw_take(0, kw_ref(32'h2b7e1516));

        // Reset pulsed during RUN_ST beat 2.
        st_accept(0, D3);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk1("midrst_busy", busy_a, 1'b0);
        chk1("midrst_st_valid", sov_a, 1'b0);
        chk1("midrst_kw_valid", kov_a, 1'b0);
        chk1("midrst_st_ready", sr_a, 1'b0);
        chk1("midrst_kw_ready", kr_a, 1'b0);
        chk("midrst_st_out", so_a, 128'd0);
        chk("midrst_kw_out", {96'd0, ko_a}, 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk1("midrst_no_valid", sov_a, 1'b0);
        end
        st_accept(0, D3);
        st_wait(0, 4);
        st_take(0, sub_ref(D3));

        // Contention after reset: KW first, then ST wins the next pair.
        do_reset();
        si_a = D2; ki_a = 32'h09cf4f3c; sv_a = 1'b1; kv_a = 1'b1;
        #1;
        chk1("cont1_kw_ready", kr_a, 1'b1);
        chk1("cont1_st_ready", sr_a, 1'b0);
        tick();
        kv_a = 1'b0;
        chk1("cont1_st_blocked", sr_a, 1'b0);
        kw_wait(0, 1);
        chk1("cont1_st_still_blocked", sr_a, 1'b0);
        chk("cont1_kw_out", {96'd0, ko_a}, {96'd0, 32'h018a84eb});
        ki_a = 32'hc0ffee11; kv_a = 1'b1; kor_a = 1'b1;
        tick();
        kor_a = 1'b0;
        chk1("cont2_st_ready", sr_a, 1'b1);
        chk1("cont2_kw_ready", kr_a, 1'b0);
        tick();
        sv_a = 1'b0;
        st_wait(0, 4);
        st_take(0, sub_ref(D2));
        chk1("cont2_kw_pending", kr_a, 1'b1);
        kw_accept(0, 32'hc0ffee11);
        kw_wait(0, 1);
        kw_take(0, kw_ref(32'hc0ffee11));

        // Every byte value through the ST path.
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < 16; i++) d[127 - 8*i -: 8] = 8'(r * 16 + i);
            st_accept(0, d);
            st_wait(0, 4);
            st_take(0, sub_ref(d));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
